// File: rtl/mmio_pkg.sv
// ============================================================================
// mmio_pkg : MMIO addresses, status bit indices and UART TX queue types
// Revision : 1.0
// ============================================================================
`default_nettype none

package mmio_pkg;

   localparam logic [31:0] UART_CTRL_ADDR  = 32'h8000_0000;
   localparam logic [31:0] UART_TX_ADDR    = 32'h8000_0008;
   localparam int          TX_NOT_FULL_BIT = 0;
   localparam int          RX_VALID_BIT    = 1;
   localparam int          TXQ_DEPTH       = 8;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } txq_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_queue_if.sv
// ============================================================================
// uart_tx_queue_if : XM-stage store side, transmitter handshake and status
// Revision : 1.0  (stats signals present when UART_TXQ_STATS_EN is defined)
// ============================================================================
`default_nettype none

interface uart_tx_queue_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
);
   logic              wr_req;
   logic [DATA_W-1:0] wr_data;
   logic              ext_stall;
   logic              txq_stall;
   logic [DATA_W-1:0] uart_tx_data;
   logic              uart_tx_valid;
   logic              uart_tx_ready;
   logic              tx_not_full;
   logic              tx_empty;
   logic [CNT_W-1:0]  occupancy;
`ifdef UART_TXQ_STATS_EN
   logic              stats_clr;
   logic [31:0]       stat_bytes;
   logic [31:0]       stat_stall_cycles;

   modport slave (
      input  wr_req, wr_data, ext_stall, uart_tx_ready, stats_clr,
      output txq_stall, uart_tx_data, uart_tx_valid, tx_not_full, tx_empty,
             occupancy, stat_bytes, stat_stall_cycles
   );
   modport master (
      output wr_req, wr_data, ext_stall, uart_tx_ready, stats_clr,
      input  txq_stall, uart_tx_data, uart_tx_valid, tx_not_full, tx_empty,
             occupancy, stat_bytes, stat_stall_cycles
   );
`else
   modport slave (
      input  wr_req, wr_data, ext_stall, uart_tx_ready,
      output txq_stall, uart_tx_data, uart_tx_valid, tx_not_full, tx_empty,
             occupancy
   );
   modport master (
      output wr_req, wr_data, ext_stall, uart_tx_ready,
      input  txq_stall, uart_tx_data, uart_tx_valid, tx_not_full, tx_empty,
             occupancy
   );
`endif
endinterface

`default_nettype wire

// File: rtl/txq_mem.sv
// ============================================================================
// txq_mem : DEPTH x DATA_W register array, synchronous write, async read
// Revision : 1.0
// ============================================================================
`default_nettype none

module txq_mem #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  wire logic              clk,
   input  wire logic              wr_en_i,
   input  wire logic [PTR_W-1:0]  wr_addr_i,
   input  wire logic [DATA_W-1:0] wr_data_i,
   input  wire logic [PTR_W-1:0]  rd_addr_i,
   output      logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/uart_tx_queue.sv
// ============================================================================
// uart_tx_queue : FWFT byte queue between XM-stage UART stores and the UART
//                 transmitter; optional counters under UART_TXQ_STATS_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_queue
   import mmio_pkg::*;
#(
   parameter int DEPTH  = TXQ_DEPTH,
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   uart_tx_queue_if.slave   bus
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] w_rd_data;
   txq_state_e        w_state;
   logic              w_full, w_empty, w_push, w_pop, w_stall;

   // State is decoded from the registered count alone, keeping ready off the stall path
   always_comb begin
      w_state = ST_PARTIAL;
      if (count_q == '0) begin
         w_state = ST_EMPTY;
      end else if (count_q == CNT_W'(DEPTH)) begin
         w_state = ST_FULL;
      end
   end

   assign w_full  = (w_state == ST_FULL);
   assign w_empty = (w_state == ST_EMPTY);
   assign w_push  = bus.wr_req & ~w_full & ~bus.ext_stall;
   assign w_pop   = ~w_empty & bus.uart_tx_ready;
   assign w_stall = bus.wr_req & w_full;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   txq_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (w_push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (bus.wr_data),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (w_rd_data)
   );

   assign bus.txq_stall     = w_stall;
   assign bus.uart_tx_data  = w_rd_data;
   assign bus.uart_tx_valid = ~w_empty;
   assign bus.tx_not_full   = ~w_full;
   assign bus.tx_empty      = w_empty;
   assign bus.occupancy     = count_q;

`ifdef UART_TXQ_STATS_EN
   logic [31:0] stat_bytes_q;
   logic [31:0] stat_stall_q;

   // Clear wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (!rst_n || bus.stats_clr) begin
         stat_bytes_q <= '0;
         stat_stall_q <= '0;
      end else begin
         if (w_pop) begin
            stat_bytes_q <= stat_bytes_q + 32'd1;
         end
         if (w_stall) begin
            stat_stall_q <= stat_stall_q + 32'd1;
         end
      end
   end

   assign bus.stat_bytes        = stat_bytes_q;
   assign bus.stat_stall_cycles = stat_stall_q;
`endif

endmodule

`default_nettype wire
